// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap entry/exit sequencer for the RV32 core.
// Detects a trap or MRET in decode, stalls and flushes the pipeline, writes
// the trap CSRs one per cycle over the single CSR write port and finally
// redirects the PC to the trap handler or back to mepc.
module trap_controller #(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342,
  parameter logic [11:0] CSR_MTVAL   = 12'h343
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [31:0]           i_inst,
  input  logic                  i_isIllegal,
  input  logic                  i_isECALL,
  input  logic                  i_isEBREAK,
  input  logic                  i_isMRET,
  input  logic                  i_irqPending,
  input  logic [DATA_WIDTH-1:0] i_mstatus,
  input  logic [DATA_WIDTH-1:0] i_mtvec,
  input  logic [DATA_WIDTH-1:0] i_mepc,
  output logic                  o_stall,
  output logic                  o_flush,
  output logic                  o_csrWrEnable,
  output logic [11:0]           o_csrWrAddr,
  output logic [DATA_WIDTH-1:0] o_csrWrData,
  output logic                  o_pcLoad,
  output logic [DATA_WIDTH-1:0] o_pcNext
);

  // Cause codes; the interrupt cause carries the MSB interrupt flag.
  localparam logic [DATA_WIDTH-1:0] CAUSE_IRQ     = {1'b1, {(DATA_WIDTH-5){1'b0}}, 4'hB};
  localparam logic [DATA_WIDTH-1:0] CAUSE_ILLEGAL = DATA_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] CAUSE_EBREAK  = DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL   = DATA_WIDTH'(11);

  typedef enum logic [2:0] {
    IDLE,
    WR_EPC,
    WR_CAUSE,
    WR_TVAL,
    WR_STATUS,
    JUMP,
    MRET_STATUS,
    MRET_JUMP
  } TrapState;

  TrapState              state;
  logic [DATA_WIDTH-1:0] causeLatched;
  logic [DATA_WIDTH-1:0] tvalLatched;
  logic [DATA_WIDTH-1:0] mstatusLatched;
  logic [DATA_WIDTH-1:0] mtvecLatched;
  logic [DATA_WIDTH-1:0] mepcLatched;

  logic                  irqTaken;
  logic                  detect;
  logic                  isReturn;
  logic [DATA_WIDTH-1:0] trapCause;
  logic [DATA_WIDTH-1:0] trapTval;
  logic [DATA_WIDTH-1:0] handlerBase;
  logic [DATA_WIDTH-1:0] vectorOffset;
  logic [DATA_WIDTH-1:0] handlerTarget;

  // mstatus on trap entry: MPIE takes the old MIE, MIE cleared, MPP = machine.
  function automatic logic [DATA_WIDTH-1:0] trapStatusOf(input logic [DATA_WIDTH-1:0] status);
    logic [DATA_WIDTH-1:0] result;
    result        = status;
    result[7]     = status[3];
    result[3]     = 1'b0;
    result[12:11] = 2'b11;
    return result;
  endfunction

  // mstatus on MRET: MIE restored from MPIE, MPIE set, MPP kept at machine.
  function automatic logic [DATA_WIDTH-1:0] mretStatusOf(input logic [DATA_WIDTH-1:0] status);
    logic [DATA_WIDTH-1:0] result;
    result        = status;
    result[3]     = status[7];
    result[7]     = 1'b1;
    result[12:11] = 2'b11;
    return result;
  endfunction

  // Classify the decode-stage instruction in priority order; only IDLE listens,
  // and reset suppresses any new detection in the cycle it is asserted.
  always_comb begin
    irqTaken  = i_irqPending & i_mstatus[3];
    detect    = 1'b0;
    isReturn  = 1'b0;
    trapCause = '0;
    trapTval  = '0;
    if ((state == IDLE) && i_valid && !i_reset) begin
      if (irqTaken) begin
        detect    = 1'b1;
        trapCause = CAUSE_IRQ;
      end else if (i_isIllegal) begin
        detect    = 1'b1;
        trapCause = CAUSE_ILLEGAL;
        trapTval  = DATA_WIDTH'(i_inst);
      end else if (i_isEBREAK) begin
        detect    = 1'b1;
        trapCause = CAUSE_EBREAK;
        trapTval  = i_pc;
      end else if (i_isECALL) begin
        detect    = 1'b1;
        trapCause = CAUSE_ECALL;
      end else if (i_isMRET) begin
        detect    = 1'b1;
        isReturn  = 1'b1;
      end
    end
  end

  // Handler address: direct mode uses the base, vectored mode offsets
  // interrupts by 4*cause; synchronous exceptions always go to the base.
  always_comb begin
    handlerBase   = {mtvecLatched[DATA_WIDTH-1:2], 2'b00};
    vectorOffset  = {causeLatched[DATA_WIDTH-3:0], 2'b00};
    handlerTarget = handlerBase;
    if ((mtvecLatched[1:0] == 2'b01) && causeLatched[DATA_WIDTH-1]) begin
      handlerTarget = handlerBase + vectorOffset;
    end
  end

  // The detect cycle itself stalls and flushes; every sequencer state stalls.
  always_comb begin
    o_flush = detect;
    o_stall = (state != IDLE) | detect;
  end

  // Sequencer: latches CSR snapshots at detect, then steps through one CSR
  // write per cycle with registered write/redirect outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= IDLE;
      causeLatched   <= '0;
      tvalLatched    <= '0;
      mstatusLatched <= '0;
      mtvecLatched   <= '0;
      mepcLatched    <= '0;
      o_csrWrEnable  <= 1'b0;
      o_csrWrAddr    <= '0;
      o_csrWrData    <= '0;
      o_pcLoad       <= 1'b0;
      o_pcNext       <= '0;
    end else begin
      o_csrWrEnable <= 1'b0;
      o_csrWrAddr   <= '0;
      o_csrWrData   <= '0;
      o_pcLoad      <= 1'b0;
      o_pcNext      <= '0;
      case (state)
        IDLE: begin
          if (detect) begin
            causeLatched   <= trapCause;
            tvalLatched    <= trapTval;
            mstatusLatched <= i_mstatus;
            mtvecLatched   <= i_mtvec;
            mepcLatched    <= i_mepc;
            o_csrWrEnable  <= 1'b1;
            if (isReturn) begin
              state       <= MRET_STATUS;
              o_csrWrAddr <= CSR_MSTATUS;
              o_csrWrData <= mretStatusOf(i_mstatus);
            end else begin
              state       <= WR_EPC;
              o_csrWrAddr <= CSR_MEPC;
              o_csrWrData <= {i_pc[DATA_WIDTH-1:2], 2'b00};
            end
          end
        end
        WR_EPC: begin
          state         <= WR_CAUSE;
          o_csrWrEnable <= 1'b1;
          o_csrWrAddr   <= CSR_MCAUSE;
          o_csrWrData   <= causeLatched;
        end
        WR_CAUSE: begin
          state         <= WR_TVAL;
          o_csrWrEnable <= 1'b1;
          o_csrWrAddr   <= CSR_MTVAL;
          o_csrWrData   <= tvalLatched;
        end
        WR_TVAL: begin
          state         <= WR_STATUS;
          o_csrWrEnable <= 1'b1;
          o_csrWrAddr   <= CSR_MSTATUS;
          o_csrWrData   <= trapStatusOf(mstatusLatched);
        end
        WR_STATUS: begin
          state    <= JUMP;
          o_pcLoad <= 1'b1;
          o_pcNext <= handlerTarget;
        end
        JUMP: begin
          state <= IDLE;
        end
        MRET_STATUS: begin
          state    <= MRET_JUMP;
          o_pcLoad <= 1'b1;
          o_pcNext <= {mepcLatched[DATA_WIDTH-1:2], 2'b00};
        end
        MRET_JUMP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
